// File: rtl/image_sprite_writer.sv
// image_sprite_writer: captures one raster-order RGB888 frame into a 2-bit luma image BRAM.
//   Clock/reset: pixel_clk_in (rising edge), rst_in (synchronous, active-high).
//   Control:     start_in arms a capture; busy_out is high outside IDLE.
//   Pixel in:    pixel_valid_in / pixel_ready_out handshake, pixel_sof_in, pixel_in (R[23:16] G[15:8] B[7:0]).
//   BRAM write:  wr_en_out, wr_addr_out (x + y*WIDTH), wr_data_out (luma[7:6]), two cycles after acceptance.
//   Status:      frame_done_out pulses with the final write; sof_error_out pulses with a mid-frame SOF write.
//   Option:      define IMAGE_SPRITE_WRITER_DITHER_EN to add 2x2 ordered dithering before quantisation.
module image_sprite_writer #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic                              pixel_clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic                              pixel_valid_in,
    output logic                              pixel_ready_out,
    input  logic                              pixel_sof_in,
    input  logic [23:0]                       pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr_out,
    output logic [1:0]                        wr_data_out,
    output logic                              wr_en_out,
    output logic                              busy_out,
    output logic                              frame_done_out,
    output logic                              sof_error_out
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH*HEIGHT);
    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, FLUSH} state_t;
    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            ready_q, ready_d, busy_q, busy_d;
    logic            s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_err_q, s1_err_d;
    logic [AW-1:0]   s1_addr_q, s1_addr_d;
    logic [23:0]     s1_pix_q, s1_pix_d;
    logic            wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      wr_data_q, wr_data_d;
    logic            acc, wr, x_end, at_last;
    logic [10:0]     luma_sum;
    logic [7:0]      luma;
`ifdef IMAGE_SPRITE_WRITER_DITHER_EN
    logic [7:0]      dith;
    logic [8:0]      dith_sum;
    logic [7:0]      sat;
`endif
    always_comb begin
        acc       = pixel_valid_in && ready_q;
        // In WAIT_SOF only the SOF pixel is written; everything else is dropped.
        wr        = acc && (pixel_sof_in || state_q == CAPTURE);
        x_end     = x_q == XW'(WIDTH-1);
        at_last   = x_end && y_q == YW'(HEIGHT-1);
        s1_vld_d  = wr;
        s1_pix_d  = pixel_in;
        s1_addr_d = pixel_sof_in ? '0 : {y_q, x_q};
        s1_last_d = wr && !pixel_sof_in && at_last;
        s1_err_d  = wr && pixel_sof_in && state_q == CAPTURE && (x_q != '0 || y_q != '0);
        // An SOF pixel always lands at (0,0), so the next position is (1,0).
        x_d = !wr ? x_q : pixel_sof_in ? XW'(1) : x_end ? '0 : x_q + XW'(1);
        y_d = !wr ? y_q : (pixel_sof_in || at_last) ? '0 : x_end ? y_q + YW'(1) : y_q;
        // FLUSH leaves once the final write is on the outputs.
        state_d = (state_q == IDLE && start_in)   ? WAIT_SOF :
                  (state_q == WAIT_SOF && wr)     ? CAPTURE  :
                  (state_q == CAPTURE && s1_last_d) ? FLUSH  :
                  (state_q == FLUSH && done_q)    ? IDLE     : state_q;
        ready_d   = state_d == WAIT_SOF || state_d == CAPTURE;
        busy_d    = state_d != IDLE;
        luma_sum  = 11'({s1_pix_q[23:16], 1'b0}) + 11'(s1_pix_q[15:8]) * 11'd5 + 11'(s1_pix_q[7:0]);
        luma      = 8'(luma_sum >> 3);
`ifdef IMAGE_SPRITE_WRITER_DITHER_EN
        // Bayer offset from (x[0], y[0]) of the written position; saturate at 255.
        dith      = s1_addr_q[0] ? (s1_addr_q[XW] ? 8'd16 : 8'd32) : (s1_addr_q[XW] ? 8'd48 : 8'd0);
        dith_sum  = 9'(luma) + 9'(dith);
        sat       = dith_sum[8] ? 8'hFF : dith_sum[7:0];
        wr_data_d = 2'(sat >> 6);
`else
        wr_data_d = 2'(luma >> 6);
`endif
        wr_en_d   = s1_vld_q;
        wr_addr_d = s1_addr_q;
        done_d    = s1_vld_q && s1_last_q;
        err_d     = s1_vld_q && s1_err_q;
    end
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_pix_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_err_q  <= s1_err_d;
            s1_addr_q <= s1_addr_d;
            s1_pix_q  <= s1_pix_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    assign pixel_ready_out = ready_q;
    assign busy_out        = busy_q;
    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign frame_done_out  = done_q;
    assign sof_error_out   = err_q;
endmodule

// File: tb/tb_image_sprite_writer.sv
// tb_image_sprite_writer: table-driven and scoreboard bench for image_sprite_writer at WIDTH=4, HEIGHT=2.
module tb_image_sprite_writer;
    localparam int W = 4;
    localparam int H = 2;
    localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_FLUSH = 3;
    logic        clk = 1'b0;
    logic        rst, start, valid, sof;
    logic [23:0] pix;
    logic        ready, wr_en, busy, done, err;
    logic [2:0]  addr;
    logic [1:0]  data;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ms = M_IDLE, mx = 0, my = 0, fc = 0;
    typedef struct { int cyc; logic [2:0] addr; logic [1:0] data; logic done; logic err; } exp_t;
    typedef struct { logic [23:0] pix; int dnd; int dd; } vec_t;
    exp_t sb[$];
    vec_t tbl[8];

    image_sprite_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in(clk), .rst_in(rst), .start_in(start), .pixel_valid_in(valid),
        .pixel_ready_out(ready), .pixel_sof_in(sof), .pixel_in(pix), .wr_addr_out(addr),
        .wr_data_out(data), .wr_en_out(wr_en), .busy_out(busy), .frame_done_out(done),
        .sof_error_out(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] model_data(input logic [23:0] p, input int x, input int y);
        int yv;
        yv = (2 * p[23:16] + 5 * p[15:8] + p[7:0]) >> 3;
`ifdef IMAGE_SPRITE_WRITER_DITHER_EN
        yv = yv + ((x % 2 == 0) ? ((y % 2 == 0) ? 0 : 48) : ((y % 2 == 0) ? 32 : 16));
        if (yv > 255) yv = 255;
`endif
        return 2'(yv >> 6);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int a, input logic [1:0] d, input logic dn, input logic e);
        sb.push_back('{cyc + 2, 3'(a), d, dn, e});
    endtask

    // Drive one cycle of inputs, check ready/busy against the model, predict writes.
    task automatic step(input logic st, input logic v, input logic s, input logic [23:0] p, input int ovr);
        logic acc, last;
        logic [1:0] d;
        start = st; valid = v; sof = s; pix = p;
        chk("ready", ready, (ms == M_WAIT || ms == M_CAP));
        chk("busy", busy, ms != M_IDLE);
        acc = v && (ms == M_WAIT || ms == M_CAP);
        case (ms)
            M_IDLE: if (st) ms = M_WAIT;
            M_WAIT: if (acc && s) begin
                push(0, model_data(p, 0, 0), 1'b0, 1'b0);
                mx = 1; my = 0; ms = M_CAP;
            end
            M_CAP: if (acc) begin
                if (s) begin
                    push(0, model_data(p, 0, 0), 1'b0, (mx != 0 || my != 0));
                    mx = 1; my = 0;
                end else begin
                    last = (mx == W - 1 && my == H - 1);
                    d = (ovr >= 0) ? 2'(ovr) : model_data(p, mx, my);
                    push(my * W + mx, d, last, 1'b0);
                    if (mx == W - 1) begin mx = 0; my = last ? 0 : my + 1; end
                    else mx++;
                    if (last) begin ms = M_FLUSH; fc = 0; end
                end
            end
            default: if (fc == 1) ms = M_IDLE; else fc = 1;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0, -1);
    endtask

    task automatic frame(input int n, input logic [23:0] p);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, i == 0, (p == 24'h1) ? 24'($urandom) : p, -1);
    endtask

    // Reset mid-flow: writes already due this cycle still emerge, later ones are dropped.
    task automatic do_rst(input int n);
        exp_t keep[$];
        rst = 1'b1; start = 1'b0; valid = 1'b0; sof = 1'b0;
        foreach (sb[i]) if (sb[i].cyc <= cyc) keep.push_back(sb[i]);
        sb = keep;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        chk("rst_sof_err", err, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        rst = 1'b0;
        ms = M_IDLE; mx = 0; my = 0; fc = 0;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            tests++; fails++;
            $display("FAIL missing_write: no write observed, expected addr %0d at cycle %0d", sb[0].addr, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (wr_en === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, expected no write", addr, data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.addr !== addr || e.data !== data || e.done !== done || e.err !== err) begin
                    fails++;
                    $display("FAIL write: cyc %0d addr %0d data %0d done %b err %b, expected cyc %0d addr %0d data %0d done %b err %b",
                             cyc, addr, data, done, err, e.cyc, e.addr, e.data, e.done, e.err);
                end
            end
        end else if (!rst) begin
            tests++;
            if (done !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL stray_pulse: done %b sof_err %b without write at cycle %0d, expected 0 0", done, err, cyc);
            end
        end
    end

    initial begin
        tbl[0] = '{24'hFFFFFF, 3, 3};
        tbl[1] = '{24'h303030, 0, 1};
        tbl[2] = '{24'h404040, 1, 1};
        tbl[3] = '{24'h800000, 0, 1};
        tbl[4] = '{24'h404040, 1, 1};
        tbl[5] = '{24'h00FF00, 2, 2};
        tbl[6] = '{24'h0000FF, 0, 1};
        tbl[7] = '{24'hFFFFFF, 3, 3};
        start = 1'b0; valid = 1'b0; sof = 1'b0; pix = '0;
        @(negedge clk);
        do_rst(3);
        // Table frame: luma quantisation (and dither offsets) at every position.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        for (int i = 0; i < 8; i++) begin
`ifdef IMAGE_SPRITE_WRITER_DITHER_EN
            step(1'b0, 1'b1, i == 0, tbl[i].pix, tbl[i].dd);
`else
            step(1'b0, 1'b1, i == 0, tbl[i].pix, tbl[i].dnd);
`endif
        end
        // start during FLUSH is ignored.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        idle(4);
        // All-white frame back to back.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        frame(8, 24'hFFFFFF);
        idle(4);
        // Non-SOF pixels before SOF are dropped.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 24'hFFFFFF, -1);
        frame(8, 24'h000000);
        idle(4);
        // SOF re-asserted at pixel 5; start during CAPTURE ignored.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        frame(5, 24'h1);
        step(1'b1, 1'b1, 1'b1, 24'($urandom), -1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 24'($urandom), -1);
        idle(4);
        // Reset after the 3rd pixel drops the frame.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        frame(3, 24'h1);
        do_rst(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 24'hFFFFFF, -1);
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        frame(8, 24'h1);
        idle(4);
        // valid toggling every other cycle.
        step(1'b1, 1'b0, 1'b0, 24'h0, -1);
        for (int i = 0; i < 16; i++) step(1'b0, i % 2 == 0, i == 0, 24'($urandom), -1);
        idle(6);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
